// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame decoder slice.
// Contents: byte typedef, SOF marker default, MAX_LEN default, FSM state enum.
// Build option: define FRAME_CSUM_EN to add the checksum state (StCsum).
package uart_frame_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t       SOF     = 8'hA5;
  localparam int unsigned MAX_LEN = 16;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLen     = 3'd1,
    StPayload = 3'd2,
    StDrain   = 3'd4
`ifdef FRAME_CSUM_EN
    ,
    StCsum    = 3'd3
`endif
  } state_e;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / element-out bundle of the frame decoder.
// s_*: received byte stream (valid/ready) from the UART controller.
// m_*: framed payload element stream (valid/ready/last) toward the sorter.
// frame_len_o: length of the frame being drained; frame_err_o: discard pulse.
// Modports: slave = decoder side, master = byte source / element sink side.
interface uart_frame_decoder_if;
  import uart_frame_pkg::*;

  logic  s_valid_i;
  byte_t s_data_i;
  logic  s_ready_o;
  logic  m_valid_o;
  byte_t m_data_o;
  logic  m_last_o;
  logic  m_ready_i;
  byte_t frame_len_o;
  logic  frame_err_o;

  modport slave (
    input  s_valid_i, s_data_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o, frame_len_o, frame_err_o
  );

  modport master (
    output s_valid_i, s_data_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o, frame_len_o, frame_err_o
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: Depth x 8 register file, one write port, one registered read port.
// Ports: clk_i, rst_ni (async, active-low; clears only the read register),
//        we_i/waddr_i/wdata_i write port, re_i/raddr_i read request, rdata_o read data.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned Depth = MAX_LEN,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  byte_t            wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output byte_t            rdata_o
);

  byte_t mem_q [Depth];
  byte_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_decoder.sv
// Length-prefixed frame decoder: hunts for SofByte, collects L payload bytes into a buffer,
// optionally verifies a checksum, then drains the payload as an element stream with last.
// Bad length (0 or > MaxLen) or bad checksum discards the frame with a one-cycle frame_err_o.
// Ports: clk_i, rst_ni (async, active-low), bus (uart_frame_decoder_if.slave).
// Build option: FRAME_CSUM_EN adds a trailing checksum byte = (L + sum of payload) mod 256.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter byte_t       SofByte = SOF,
  parameter int unsigned MaxLen  = MAX_LEN
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  uart_frame_decoder_if.slave bus
);

  localparam int unsigned CntW    = $clog2(MaxLen + 1);
  localparam int unsigned AddrW   = $clog2(MaxLen);
  localparam byte_t       MaxLenB = byte_t'(MaxLen);
  typedef logic [CntW-1:0] cnt_t;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d, lenm1, rd_next;
  byte_t  len_q, len_d, buf_rdata;
  logic   live_q, err_q, err_d;
  logic   m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic   s_ready, accept, fire, len_bad, last_byte, buf_we, buf_re;
`ifdef FRAME_CSUM_EN
  byte_t  sum_q, sum_d;
`endif

  // live_q holds s_ready low while in reset and for nothing longer.
  assign s_ready   = live_q && (state_q != StDrain);
  assign accept    = bus.s_valid_i && s_ready;
  assign fire      = m_valid_q && bus.m_ready_i;
  assign len_bad   = (bus.s_data_i == 8'd0) || (bus.s_data_i > MaxLenB);
  assign lenm1     = cnt_t'(len_q - 8'd1);
  assign last_byte = (cnt_q == lenm1);
  // In DRAIN cnt_q is the read pointer; look one ahead so data lands with the handshake.
  assign rd_next   = fire ? cnt_q + 1'b1 : cnt_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept && bus.s_data_i == SofByte) state_d = StLen;
      StLen:     if (accept) state_d = len_bad ? StIdle : StPayload;
`ifdef FRAME_CSUM_EN
      StPayload: if (accept && last_byte) state_d = StCsum;
      StCsum:    if (accept) state_d = (bus.s_data_i == sum_q) ? StDrain : StIdle;
`else
      StPayload: if (accept && last_byte) state_d = StDrain;
`endif
      StDrain:   if (fire && m_last_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    err_d  = 1'b0;
    buf_we = 1'b0;
    buf_re = 1'b0;
    case (state_q)
      StLen:     err_d  = accept && len_bad;
      StPayload: buf_we = accept;
`ifdef FRAME_CSUM_EN
      StCsum:    err_d  = accept && (bus.s_data_i != sum_q);
`endif
      StDrain:   buf_re = !m_valid_q || (fire && !m_last_q);
      default:   ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
`ifdef FRAME_CSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      StLen: if (accept && !len_bad) begin
        len_d = bus.s_data_i;
        cnt_d = '0;
`ifdef FRAME_CSUM_EN
        sum_d = bus.s_data_i;
`endif
      end
      StPayload: if (accept) begin
        cnt_d = last_byte ? '0 : cnt_q + 1'b1;
`ifdef FRAME_CSUM_EN
        sum_d = sum_q + bus.s_data_i;
`endif
      end
      StDrain: begin
        if (fire && m_last_q) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end else if (fire || !m_valid_q) begin
          m_valid_d = 1'b1;
          cnt_d     = rd_next;
          m_last_d  = (rd_next == lenm1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q    <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
`ifdef FRAME_CSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      live_q    <= 1'b1;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
`ifdef FRAME_CSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  uart_frame_buf #(
    .Depth (MaxLen),
    .AddrW (AddrW)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (buf_we),
    .waddr_i (cnt_q[AddrW-1:0]),
    .wdata_i (bus.s_data_i),
    .re_i    (buf_re),
    .raddr_i (rd_next[AddrW-1:0]),
    .rdata_o (buf_rdata)
  );

  assign bus.s_ready_o   = s_ready;
  assign bus.m_valid_o   = m_valid_q;
  assign bus.m_data_o    = buf_rdata;
  assign bus.m_last_o    = m_last_q;
  assign bus.frame_len_o = len_q;
  assign bus.frame_err_o = err_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder; works with or without FRAME_CSUM_EN.
module tb_uart_frame_decoder;
  import uart_frame_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  uart_frame_decoder_if bus ();

  uart_frame_decoder #(
    .SofByte (SOF),
    .MaxLen  (MAX_LEN)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  byte_t tx_q[$], got_data[$], got_len[$], exp_data[$], exp_len[$];
  logic  got_last[$], exp_last[$];
  int    err_cnt = 0, err_long = 0, hold_bad = 0, rdy_bad = 0, after_last_bad = 0;
  logic  err_prev = 1'b0, stall_prev = 1'b0, last_hs_prev = 1'b0, last_prev = 1'b0;
  byte_t data_prev = '0;
  int    err_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Monitor sampled at negedge: records handshakes and protocol violations.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (err_prev && bus.frame_err_o) err_long <= err_long + 1;
      if (bus.frame_err_o) err_cnt <= err_cnt + 1;
      if (stall_prev && (!bus.m_valid_o || bus.m_data_o != data_prev ||
                         bus.m_last_o != last_prev)) hold_bad <= hold_bad + 1;
      if (bus.m_valid_o && bus.s_ready_o) rdy_bad <= rdy_bad + 1;
      if (last_hs_prev && !bus.s_ready_o) after_last_bad <= after_last_bad + 1;
      if (bus.m_valid_o && bus.m_ready_i) begin
        got_data.push_back(bus.m_data_o);
        got_last.push_back(bus.m_last_o);
        got_len.push_back(bus.frame_len_o);
      end
    end
    err_prev     <= bus.frame_err_o;
    stall_prev   <= bus.m_valid_o && !bus.m_ready_i;
    data_prev    <= bus.m_data_o;
    last_prev    <= bus.m_last_o;
    last_hs_prev <= bus.m_valid_o && bus.m_ready_i && bus.m_last_o;
  end

  // Returns 1 ns after the edge that accepted the byte.
  task automatic send_byte(input byte_t b);
    int n;
    n = 0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = b;
    @(negedge clk_i);
    while (!bus.s_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("send_ready", 32'(n < 200), 1);
    @(posedge clk_i);
    #1;
    bus.s_valid_i = 1'b0;
  endtask

  // Sends SOF, len, tx_q (and checksum when enabled); optionally queues expected output.
  task automatic send_frame(input byte_t len, input bit expect_ok);
    byte_t sum;
    sum = len;
    send_byte(SOF);
    send_byte(len);
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      sum = sum + tx_q[i];
      if (expect_ok) begin
        exp_data.push_back(tx_q[i]);
        exp_last.push_back(i == tx_q.size() - 1);
        exp_len.push_back(len);
      end
    end
`ifdef FRAME_CSUM_EN
    send_byte(sum);
`endif
  endtask

  task automatic wait_out(input string tag);
    int t;
    t = 0;
    while (got_data.size() < exp_data.size() && t < 1000) begin
      @(posedge clk_i);
      t++;
    end
    @(posedge clk_i);
    #1;
    check({tag, "_timeout"}, 32'(t < 1000), 1);
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_count"}, got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check({tag, "_data"}, got_data[i], exp_data[i]);
      check({tag, "_last"}, got_last[i], exp_last[i]);
      check({tag, "_len"}, got_len[i], exp_len[i]);
    end
    got_data.delete(); got_last.delete(); got_len.delete();
    exp_data.delete(); exp_last.delete(); exp_len.delete();
  endtask

  initial begin
    logic [3:0] pat;
    rst_ni        = 1'b0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    bus.m_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_s_ready", bus.s_ready_o, 0);
    check("rst_m_valid", bus.m_valid_o, 0);
    check("rst_m_last", bus.m_last_o, 0);
    check("rst_m_data", bus.m_data_o, 0);
    check("rst_len", bus.frame_len_o, 0);
    check("rst_err", bus.frame_err_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_ready", bus.s_ready_o, 1);

    // Basic frame with latency and DRAIN readiness checks.
    bus.m_ready_i = 1'b1;
    tx_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, 1'b1);
    check("lat_valid0", bus.m_valid_o, 0);
    check("drain_ready0", bus.s_ready_o, 0);
    @(posedge clk_i);
    #1;
    check("lat_valid1", bus.m_valid_o, 1);
    check("first_data", bus.m_data_o, 8'h11);
    check("first_len", bus.frame_len_o, 3);
    wait_out("basic");
    compare_out("basic");

    // Garbage before SOF is dropped silently.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    tx_q = '{8'h7E};
    send_frame(8'd1, 1'b1);
    wait_out("garbage");
    compare_out("garbage");
    check("garbage_no_err", err_cnt, 0);

    // Zero and oversized lengths; then a full MAX_LEN frame.
    send_byte(SOF); send_byte(8'h00);
    check("len0_pulse", bus.frame_err_o, 1);
    @(posedge clk_i); #1;
    check("len0_pulse_end", bus.frame_err_o, 0);
    send_byte(SOF); send_byte(8'h11);
    check("len17_pulse", bus.frame_err_o, 1);
    @(posedge clk_i); #1;
    check("len_err_count", err_cnt, 2);
    check("len_err_no_out", got_data.size(), 0);
    tx_q.delete();
    for (int i = 0; i < 16; i++) tx_q.push_back(byte_t'(i * 7 + 3));
    send_frame(8'd16, 1'b1);
    wait_out("maxlen");
    compare_out("maxlen");

`ifdef FRAME_CSUM_EN
    // Checksum mismatch (expected 8'h32, sent 8'h00).
    send_byte(SOF); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    check("csum_pulse", bus.frame_err_o, 1);
    @(posedge clk_i); #1;
    check("csum_err_count", err_cnt, 3);
    check("csum_no_out", got_data.size(), 0);
    tx_q = '{8'h44, 8'h55};
    send_frame(8'd2, 1'b1);
    wait_out("after_csum");
    compare_out("after_csum");
`endif

    // Downstream stalls 1-0-0-1 with a back-to-back second frame (SOF value as data).
    pat = 4'b1001;
    bus.m_ready_i = 1'b0;
    fork
      begin
        tx_q = '{8'hC1, 8'hC2, 8'hC3};
        send_frame(8'd3, 1'b1);
        tx_q = '{8'hA5, 8'h5A};
        send_frame(8'd2, 1'b1);
      end
      begin
        int k;
        k = 0;
        @(posedge clk_i); #1;
        while (got_data.size() < 5 && k < 400) begin
          bus.m_ready_i = pat[3 - (k % 4)];
          k++;
          @(posedge clk_i); #1;
        end
        bus.m_ready_i = 1'b1;
      end
    join
    wait_out("stall");
    compare_out("stall");

    // Asynchronous reset mid-payload.
    err_base = err_cnt;
    send_byte(SOF); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    rst_ni = 1'b0;
    #1;
    check("midrst_ready", bus.s_ready_o, 0);
    check("midrst_valid", bus.m_valid_o, 0);
    check("midrst_data", bus.m_data_o, 0);
    check("midrst_len", bus.frame_len_o, 0);
    check("midrst_err", bus.frame_err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("midrst_ready_after", bus.s_ready_o, 1);
    tx_q = '{8'h9A, 8'hBC};
    send_frame(8'd2, 1'b1);
    wait_out("after_rst");
    compare_out("after_rst");
    check("midrst_no_err", err_cnt, err_base);

    check("err_single_cycle", err_long, 0);
    check("hold_stable", hold_bad, 0);
    check("no_ready_in_drain", rdy_bad, 0);
    check("ready_after_last", after_last_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
